// File: rtl/osd_pkg.sv
// osd_pkg: shared fade-state type, size defaults and saturating 8-bit alpha arithmetic
package osd_pkg;
  localparam int XY_W_DEF = 12;
  localparam int BW_W_DEF = 4;
  typedef enum logic [1:0] {IDLE, FADE_IN, SHOW, FADE_OUT} fade_state_e;
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b, input logic [7:0] lim);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[7:0];
  endfunction
  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} - {1'b0, b};
    return s[8] ? 8'd0 : s[7:0];
  endfunction
endpackage

// File: rtl/osd_fade_ctrl.sv
// osd_fade_ctrl: per-frame alpha fade state machine driving the OSD window alpha
module osd_fade_ctrl
  import osd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       tick_i,
  input  logic       enable_i,
  input  logic [7:0] step_i,
  input  logic [7:0] alpha_max_i,
  output logic [7:0] alpha_o,
  output logic       busy_o
);
  fade_state_e state_q, state_d;
  logic [7:0] alpha_q, alpha_d, up, down;
  // The direction is taken from the enable sampled on this boundary, so a reversal moves alpha the new way at once
  always_comb begin
    up = (step_i == 8'd0 || state_q == SHOW) ? alpha_max_i : sat_add(alpha_q, step_i, alpha_max_i);
    down = (step_i == 8'd0) ? 8'd0 : sat_sub(alpha_q, step_i);
    alpha_d = alpha_q;
    state_d = state_q;
    if (tick_i) begin
      alpha_d = enable_i ? up : down;
      state_d = enable_i ? ((up == alpha_max_i) ? SHOW : FADE_IN) : ((down == 8'd0) ? IDLE : FADE_OUT);
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= IDLE;
      alpha_q <= '0;
    end else begin
      state_q <= state_d;
      alpha_q <= alpha_d;
    end
  assign alpha_o = alpha_q;
  assign busy_o = (state_q == FADE_IN) || (state_q == FADE_OUT);
endmodule

// File: rtl/osd_overlay_gen.sv
// osd_overlay_gen: rectangular OSD window colour and fading alpha, aligned 2 cycles behind the input video
module osd_overlay_gen
  import osd_pkg::*;
#(
  parameter int XY_W = XY_W_DEF,
  parameter int BW_W = BW_W_DEF,
  parameter bit VS_ACTIVE = 1'b1
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  input  logic            i_h_sync,
  input  logic            i_v_sync,
  input  logic            i_de,
  input  logic [7:0]      i_back_ground_0_8b,
  input  logic [7:0]      i_back_ground_1_8b,
  input  logic [7:0]      i_back_ground_2_8b,
  input  logic            i_enable,
  input  logic [XY_W-1:0] i_win_x0,
  input  logic [XY_W-1:0] i_win_x1,
  input  logic [XY_W-1:0] i_win_y0,
  input  logic [XY_W-1:0] i_win_y1,
  input  logic [BW_W-1:0] i_border_w,
  input  logic [7:0]      i_fill_0_8b,
  input  logic [7:0]      i_fill_1_8b,
  input  logic [7:0]      i_fill_2_8b,
  input  logic [7:0]      i_border_0_8b,
  input  logic [7:0]      i_border_1_8b,
  input  logic [7:0]      i_border_2_8b,
  input  logic [7:0]      i_alpha_max_8b,
  input  logic [7:0]      i_fade_step_8b,
  output logic            o_h_sync,
  output logic            o_v_sync,
  output logic            o_de,
  output logic [7:0]      o_back_ground_0_8b,
  output logic [7:0]      o_back_ground_1_8b,
  output logic [7:0]      o_back_ground_2_8b,
  output logic [7:0]      o_front_ground_0_8b,
  output logic [7:0]      o_front_ground_1_8b,
  output logic [7:0]      o_front_ground_2_8b,
  output logic [7:0]      o_alpha_8b,
  output logic            o_fade_busy
);
  logic hs_q, vs_q, de_q, hit_q, brd_q, cfg_vld_q;
  logic tick, fall, hit, brd;
  logic [23:0] bg_q, fill_q, bord_q;
  logic [XY_W-1:0] x_q, x_d, y_q, y_d, x0_q, x1_q, y0_q, y1_q, bw_ext;
  logic [BW_W-1:0] bw_q;
  logic [7:0] alpha_cur;
  // vs_q doubles as the previous v_sync level for boundary detection and de_q as the previous de
  always_comb begin
    tick = (i_v_sync == VS_ACTIVE) && (vs_q != VS_ACTIVE);
    fall = de_q && !i_de;
    x_d = i_de ? x_q + XY_W'(1) : (fall ? '0 : x_q);
    y_d = tick ? '0 : (fall ? y_q + XY_W'(1) : y_q);
    bw_ext = XY_W'(bw_q);
    hit = cfg_vld_q && i_de && x_q >= x0_q && x_q <= x1_q && y_q >= y0_q && y_q <= y1_q;
    brd = (x_q - x0_q < bw_ext) || (x1_q - x_q < bw_ext) || (y_q - y0_q < bw_ext) || (y1_q - y_q < bw_ext);
  end
  // cfg_vld_q keeps the all-zero reset window from hitting pixel (0,0) before the first boundary
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      {x_q, y_q, x0_q, x1_q, y0_q, y1_q} <= '0;
      {bw_q, fill_q, bord_q, cfg_vld_q} <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      if (tick) begin
        cfg_vld_q <= 1'b1;
        {x0_q, x1_q, y0_q, y1_q} <= {i_win_x0, i_win_x1, i_win_y0, i_win_y1};
        bw_q <= i_border_w;
        fill_q <= {i_fill_2_8b, i_fill_1_8b, i_fill_0_8b};
        bord_q <= {i_border_2_8b, i_border_1_8b, i_border_0_8b};
      end
    end
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      {hs_q, vs_q, de_q, hit_q, brd_q, bg_q} <= '0;
      {o_h_sync, o_v_sync, o_de, o_alpha_8b} <= '0;
      {o_back_ground_2_8b, o_back_ground_1_8b, o_back_ground_0_8b} <= '0;
      {o_front_ground_2_8b, o_front_ground_1_8b, o_front_ground_0_8b} <= '0;
    end else begin
      {hs_q, vs_q, de_q} <= {i_h_sync, i_v_sync, i_de};
      bg_q <= {i_back_ground_2_8b, i_back_ground_1_8b, i_back_ground_0_8b};
      hit_q <= hit;
      brd_q <= brd;
      {o_h_sync, o_v_sync, o_de} <= {hs_q, vs_q, de_q};
      {o_back_ground_2_8b, o_back_ground_1_8b, o_back_ground_0_8b} <= bg_q;
      {o_front_ground_2_8b, o_front_ground_1_8b, o_front_ground_0_8b} <= hit_q ? (brd_q ? bord_q : fill_q) : 24'd0;
      o_alpha_8b <= hit_q ? alpha_cur : 8'd0;
    end
  osd_fade_ctrl u_fade (
    .clk_i      (sys_clk),
    .rst_n_i    (rst_n),
    .tick_i     (tick),
    .enable_i   (i_enable),
    .step_i     (i_fade_step_8b),
    .alpha_max_i(i_alpha_max_8b),
    .alpha_o    (alpha_cur),
    .busy_o     (o_fade_busy)
  );
endmodule

// File: tb/tb_osd_overlay_gen.sv
// tb_osd_overlay_gen: directed 16x8-frame bench for the OSD overlay generator
module tb_osd_overlay_gen;
  localparam logic [23:0] FILL = 24'h112233;
  localparam logic [23:0] BORD = 24'hAABBCC;
  logic clk = 1'b0, rst_n = 1'b0;
  logic hs = 1'b0, vs = 1'b0, de = 1'b0, en = 1'b0;
  logic [7:0] bg0 = '0, bg1 = '0, bg2 = '0, amax = '0, step = '0;
  logic [11:0] x0 = '0, x1 = '0, y0 = '0, y1 = '0;
  logic [3:0] bw = '0;
  logic o_hs, o_vs, o_de, o_busy;
  logic [7:0] o_bg0, o_bg1, o_bg2, o_fg0, o_fg1, o_fg2, o_alpha;
  int checks = 0, failures = 0;
  logic [7:0] alpha_buf [8][16];
  logic [23:0] front_buf [8][16];
  int ox = 0, oy = 0, npix = 0;
  logic mde = 1'b0;
  logic [26:0] d1, d2;
  int fade_exp [8] = '{64, 128, 192, 255, 191, 127, 63, 0};
  logic busy_exp [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  osd_overlay_gen dut (
    .sys_clk(clk), .rst_n(rst_n), .i_h_sync(hs), .i_v_sync(vs), .i_de(de),
    .i_back_ground_0_8b(bg0), .i_back_ground_1_8b(bg1), .i_back_ground_2_8b(bg2),
    .i_enable(en), .i_win_x0(x0), .i_win_x1(x1), .i_win_y0(y0), .i_win_y1(y1),
    .i_border_w(bw),
    .i_fill_0_8b(FILL[7:0]), .i_fill_1_8b(FILL[15:8]), .i_fill_2_8b(FILL[23:16]),
    .i_border_0_8b(BORD[7:0]), .i_border_1_8b(BORD[15:8]), .i_border_2_8b(BORD[23:16]),
    .i_alpha_max_8b(amax), .i_fade_step_8b(step),
    .o_h_sync(o_hs), .o_v_sync(o_vs), .o_de(o_de),
    .o_back_ground_0_8b(o_bg0), .o_back_ground_1_8b(o_bg1), .o_back_ground_2_8b(o_bg2),
    .o_front_ground_0_8b(o_fg0), .o_front_ground_1_8b(o_fg1), .o_front_ground_2_8b(o_fg2),
    .o_alpha_8b(o_alpha), .o_fade_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d1 <= '0;
      d2 <= '0;
    end else begin
      d1 <= {hs, vs, de, bg2, bg1, bg0};
      d2 <= d1;
    end

  always @(negedge clk)
    if (rst_n) begin
      chk("delay2", {5'd0, o_hs, o_vs, o_de, o_bg2, o_bg1, o_bg0}, {5'd0, d2});
      if (!o_de) chk("blank_zero", {o_alpha, o_fg2, o_fg1, o_fg0}, 32'd0);
    end

  always @(negedge clk) begin
    mde <= o_de;
    if (o_vs) begin
      ox <= 0;
      oy <= 0;
      npix <= 0;
    end else if (o_de) begin
      if (ox < 16 && oy < 8) begin
        alpha_buf[oy][ox] <= o_alpha;
        front_buf[oy][ox] <= {o_fg2, o_fg1, o_fg0};
      end
      ox <= ox + 1;
      npix <= npix + 1;
    end else if (mde) begin
      oy <= oy + 1;
      ox <= 0;
    end
  end

  task automatic frame();
    for (int i = 0; i < 4; i++) begin @(negedge clk); vs = 1'b1; hs = 1'b0; de = 1'b0; end
    for (int i = 0; i < 2; i++) begin @(negedge clk); vs = 1'b0; end
    for (int l = 0; l < 8; l++) begin
      for (int p = 0; p < 16; p++) begin
        @(negedge clk);
        de = 1'b1;
        {bg2, bg1, bg0} = 24'($urandom);
      end
      for (int p = 0; p < 4; p++) begin @(negedge clk); de = 1'b0; hs = (p < 2); end
    end
    @(negedge clk);
    hs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] a, input int wx0, input int wx1,
                             input int wy0, input int wy1, input int wbw);
    logic hit, brd;
    chk({tag, "_npix"}, npix, 128);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) begin
        hit = x >= wx0 && x <= wx1 && y >= wy0 && y <= wy1;
        brd = (x - wx0 < wbw) || (wx1 - x < wbw) || (y - wy0 < wbw) || (wy1 - y < wbw);
        chk($sformatf("%s_px%0d_%0d", tag, x, y), {alpha_buf[y][x], front_buf[y][x]},
            hit ? {a, brd ? BORD : FILL} : 32'd0);
      end
  endtask

  task automatic set_std();
    x0 = 12'd4; x1 = 12'd11; y0 = 12'd2; y1 = 12'd5; bw = 4'd1;
    amax = 8'd200; step = 8'd255; en = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out", {o_alpha, o_fg2, o_fg1, o_fg0}, 32'd0);
    chk("rst_tim", {o_busy, o_hs, o_vs, o_de, o_bg2, o_bg1, o_bg0}, 32'd0);
    rst_n = 1'b1;
    set_std();
    frame();
    frame();
    check_frame("win", 8'd200, 4, 11, 2, 5, 1);
    chk("spot_in_alpha", alpha_buf[3][6], 200);
    chk("spot_row2", front_buf[2][6], BORD);
    chk("spot_row5", front_buf[5][8], BORD);
    chk("spot_col4", front_buf[3][4], BORD);
    chk("spot_col11", front_buf[4][11], BORD);
    chk("spot_fill", front_buf[3][5], FILL);
    chk("spot_out_left", {alpha_buf[3][3], front_buf[3][3]}, 0);
    chk("spot_out_top", {alpha_buf[1][6], front_buf[1][6]}, 0);
    chk("show_busy", o_busy, 0);
    en = 1'b0;
    frame();
    check_frame("off", 8'd0, 4, 11, 2, 5, 1);
    chk("off_busy", o_busy, 0);
    step = 8'd64;
    amax = 8'd255;
    for (int f = 0; f < 8; f++) begin
      en = (f < 4);
      frame();
      chk($sformatf("fade_alpha%0d", f), alpha_buf[3][6], fade_exp[f]);
      chk($sformatf("fade_busy%0d", f), o_busy, busy_exp[f]);
    end
    en = 1'b1;
    frame();
    chk("rev_up1", alpha_buf[3][6], 64);
    frame();
    chk("rev_up2", alpha_buf[3][6], 128);
    en = 1'b0;
    frame();
    chk("rev_down", alpha_buf[3][6], 64);
    chk("rev_busy", o_busy, 1);
    frame();
    chk("rev_idle", alpha_buf[3][6], 0);
    chk("rev_idle_busy", o_busy, 0);
    x0 = 12'd10; x1 = 12'd3; step = 8'd0; amax = 8'd200; en = 1'b1;
    frame();
    check_frame("empty", 8'd200, 10, 3, 2, 5, 1);
    chk("empty_busy", o_busy, 0);
    frame();
    chk("empty_again", {alpha_buf[3][6], front_buf[3][6]}, 0);
    set_std();
    frame();
    check_frame("pre_mid", 8'd200, 4, 11, 2, 5, 1);
    fork
      frame();
      begin
        repeat (80) @(negedge clk);
        x0 = 12'd0; x1 = 12'd3; y0 = 12'd0; y1 = 12'd1;
      end
    join
    check_frame("mid_same", 8'd200, 4, 11, 2, 5, 1);
    frame();
    check_frame("mid_new", 8'd200, 0, 3, 0, 1, 1);
    set_std();
    frame();
    fork
      frame();
      begin
        repeat (75) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out", {o_alpha, o_fg2, o_fg1, o_fg0}, 32'd0);
        chk("midrst_tim", {o_busy, o_hs, o_vs, o_de, o_bg2, o_bg1, o_bg0}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    frame();
    check_frame("after_rst", 8'd200, 4, 11, 2, 5, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
